// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control unit: opcode constants,
// opcode classes and the sequencer state enumeration.
package control_pkg;

  localparam int unsigned OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_ADD       = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_ALU3_LAST = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_IMM_FIRST = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_IMM_LAST  = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_MUL       = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_DIV       = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_LD        = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_ST        = 5'b10011;
  localparam logic [OPCODE_W-1:0] OP_NOP       = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT      = 5'b11011;

  typedef enum logic [3:0] {
    C_ALU3, C_IMM, C_MUL, C_DIV, C_LD, C_ST, C_NOP, C_HALT, C_UNDEF
  } op_class_t;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSED, S_HALTED
  } state_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] ir);
    return ir[31:27];
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode-to-class decoder.
module op_class_decode
  import control_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output op_class_t           class_o
);

  always_comb begin
    class_o = C_UNDEF;
    if (opcode_i <= OP_ALU3_LAST) begin
      class_o = C_ALU3;
    end else if (opcode_i <= OP_IMM_LAST) begin
      class_o = C_IMM;
    end else begin
      case (opcode_i)
        OP_MUL:  class_o = C_MUL;
        OP_DIV:  class_o = C_DIV;
        OP_LD:   class_o = C_LD;
        OP_ST:   class_o = C_ST;
        OP_NOP:  class_o = C_NOP;
        OP_HALT: class_o = C_HALT;
        default: class_o = C_UNDEF;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0-T2), class-specific execute
// (T3-T7), plus RESET/PAUSED/HALTED housekeeping states.
module control_unit
  import control_pkg::*;
#(
  parameter bit ILLEGAL_HALTS = 1'b0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IRbits,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        IRin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDRread,
  output logic        Read,
  output logic        Write,
  output logic        RYin,
  output logic        RZinLo,
  output logic        RZinHi,
  output logic        RZoutLo,
  output logic        RZoutHi,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        Run,
  output logic        illegal_op
);

  state_t    state_q, state_d;
  state_t    entry_state;
  op_class_t op_class;
  logic      ir_unused;

  // Class is decoded from the IR register itself; it is stable from T3 on
  // because IR loads on the T2->T3 edge.
  op_class_decode u_decode (
    .opcode_i (opcode_of(IRbits)),
    .class_o  (op_class)
  );

  assign ir_unused   = ^IRbits[26:0];
  assign entry_state = stop ? S_PAUSED : S_T0;

  always_ff @(posedge clock) begin
    if (clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = entry_state;
      S_T0:     state_d = S_T1;
      S_T1:     if (mem_ready) state_d = S_T2;
      S_T2:     state_d = S_T3;
      S_T3: begin
        case (op_class)
          C_NOP:   state_d = entry_state;
          C_HALT:  state_d = S_HALTED;
          C_UNDEF: state_d = ILLEGAL_HALTS ? S_HALTED : entry_state;
          default: state_d = S_T4;
        endcase
      end
      S_T4:     state_d = S_T5;
      S_T5:     state_d = (op_class == C_ALU3 || op_class == C_IMM) ? entry_state : S_T6;
      S_T6: begin
        case (op_class)
          C_LD:    if (mem_ready) state_d = S_T7;
          C_ST:    state_d = S_T7;
          default: state_d = entry_state;
        endcase
      end
      S_T7:     if (op_class != C_ST || mem_ready) state_d = entry_state;
      S_PAUSED: if (!stop) state_d = S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RESET;
    endcase
  end

  always_comb begin
    {PCout, MARin, IncPC, PCin, IRin, MDRin, MDRout, MDRread, Read, Write} = '0;
    {RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, LOin} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, illegal_op} = '0;
    Run = !(state_q inside {S_RESET, S_PAUSED, S_HALTED});
    case (state_q)
      S_T0: {PCout, MARin, IncPC, RZinLo} = '1;
      S_T1: {RZoutLo, PCin, Read, MDRread, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: begin
        case (op_class)
          C_ALU3, C_IMM: {Grb, Rout, RYin} = '1;
          C_MUL, C_DIV:  {Gra, Rout, RYin} = '1;
          C_LD, C_ST:    {Grb, BAout, RYin} = '1;
          C_UNDEF:       illegal_op = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          C_ALU3:       {Grc, Rout, RZinLo} = '1;
          C_MUL, C_DIV: {Grb, Rout, RZinLo, RZinHi} = '1;
          default:      {Cout, RZinLo} = '1;
        endcase
      end
      S_T5: begin
        case (op_class)
          C_MUL, C_DIV: {RZoutLo, LOin} = '1;
          C_LD, C_ST:   {RZoutLo, MARin} = '1;
          default:      {RZoutLo, Gra, Rin} = '1;
        endcase
      end
      S_T6: begin
        case (op_class)
          C_LD:    {Read, MDRread, MDRin} = '1;
          C_ST:    {Gra, Rout, MDRin} = '1;
          default: {RZoutHi, HIin} = '1;
        endcase
      end
      S_T7: begin
        if (op_class == C_ST) Write = 1'b1;
        else                  {MDRout, Gra, Rin} = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench: two control units (undefined opcode as NOP and
// as HALT) share stimulus; a per-cycle expected strobe vector is queued per unit.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clear_a, clear_b, mem_ready, stop, last_stop;
  logic [31:0] ir;
  wire  [25:0] va, vb;

  always #5 clk = ~clk;

  localparam logic [25:0] PCOUT = 26'h1 << 0,  MARIN = 26'h1 << 1,  INCPC = 26'h1 << 2;
  localparam logic [25:0] PCIN = 26'h1 << 3,   IRIN = 26'h1 << 4,   MDRIN = 26'h1 << 5;
  localparam logic [25:0] MDROUT = 26'h1 << 6, MDRREAD = 26'h1 << 7, READ = 26'h1 << 8;
  localparam logic [25:0] WRITE = 26'h1 << 9,  RYIN = 26'h1 << 10,  RZINLO = 26'h1 << 11;
  localparam logic [25:0] RZINHI = 26'h1 << 12, RZOUTLO = 26'h1 << 13, RZOUTHI = 26'h1 << 14;
  localparam logic [25:0] HIIN = 26'h1 << 15,  LOIN = 26'h1 << 16,  GRA = 26'h1 << 17;
  localparam logic [25:0] GRB = 26'h1 << 18,   GRC = 26'h1 << 19,   RIN = 26'h1 << 20;
  localparam logic [25:0] ROUT = 26'h1 << 21,  BAOUT = 26'h1 << 22, COUT = 26'h1 << 23;
  localparam logic [25:0] RUN = 26'h1 << 24,   ILL = 26'h1 << 25;
  localparam logic [25:0] T0V = PCOUT | MARIN | INCPC | RZINLO | RUN;
  localparam logic [25:0] T1V = RZOUTLO | PCIN | READ | MDRREAD | MDRIN | RUN;
  localparam logic [25:0] T2V = MDROUT | IRIN | RUN;

  localparam int K_ALU3 = 0, K_IMM = 1, K_MUL = 2, K_DIV = 3, K_LD = 4, K_ST = 5;
  localparam int K_NOP = 6, K_HALT = 7, K_UNDEF = 8;

  control_unit #(.ILLEGAL_HALTS(1'b0)) u_nop (
    .clock(clk), .clear(clear_a), .IRbits(ir), .mem_ready(mem_ready), .stop(stop),
    .PCout(va[0]), .MARin(va[1]), .IncPC(va[2]), .PCin(va[3]), .IRin(va[4]),
    .MDRin(va[5]), .MDRout(va[6]), .MDRread(va[7]), .Read(va[8]), .Write(va[9]),
    .RYin(va[10]), .RZinLo(va[11]), .RZinHi(va[12]), .RZoutLo(va[13]), .RZoutHi(va[14]),
    .HIin(va[15]), .LOin(va[16]), .Gra(va[17]), .Grb(va[18]), .Grc(va[19]),
    .Rin(va[20]), .Rout(va[21]), .BAout(va[22]), .Cout(va[23]), .Run(va[24]),
    .illegal_op(va[25])
  );

  control_unit #(.ILLEGAL_HALTS(1'b1)) u_halt (
    .clock(clk), .clear(clear_b), .IRbits(ir), .mem_ready(mem_ready), .stop(stop),
    .PCout(vb[0]), .MARin(vb[1]), .IncPC(vb[2]), .PCin(vb[3]), .IRin(vb[4]),
    .MDRin(vb[5]), .MDRout(vb[6]), .MDRread(vb[7]), .Read(vb[8]), .Write(vb[9]),
    .RYin(vb[10]), .RZinLo(vb[11]), .RZinHi(vb[12]), .RZoutLo(vb[13]), .RZoutHi(vb[14]),
    .HIin(vb[15]), .LOin(vb[16]), .Gra(vb[17]), .Grb(vb[18]), .Grc(vb[19]),
    .Rin(vb[20]), .Rout(vb[21]), .BAout(vb[22]), .Cout(vb[23]), .Run(vb[24]),
    .illegal_op(vb[25])
  );

  logic [25:0] qa[$], qb[$];
  string       ql[$];
  logic [25:0] ea, eb;
  string       lbl;
  int          checks = 0, errors = 0;

  // Monitor: every cycle with a queued expectation is compared on the falling edge.
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front(); eb = qb.pop_front(); lbl = ql.pop_front();
      checks++;
      if (va !== ea) begin
        errors++;
        $display("FAIL %s nop-unit got=%h exp=%h t=%0t", lbl, va, ea, $time);
      end
      checks++;
      if (vb !== eb) begin
        errors++;
        $display("FAIL %s halt-unit got=%h exp=%h t=%0t", lbl, vb, eb, $time);
      end
    end
  end

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit rnd_stop();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic int cls_of(input logic [4:0] op);
    if (op < 13) return K_ALU3;
    if (op < 16) return K_IMM;
    case (op)
      5'd16: return K_MUL;
      5'd17: return K_DIV;
      5'd18: return K_LD;
      5'd19: return K_ST;
      5'd26: return K_NOP;
      5'd27: return K_HALT;
      default: return K_UNDEF;
    endcase
  endfunction

  task automatic cyc(input bit ca, input bit cb, input bit mr, input bit st,
                     input logic [25:0] xa, input logic [25:0] xb, input string n);
    clear_a = ca; clear_b = cb; mem_ready = mr; stop = st;
    qa.push_back(xa); qb.push_back(xb); ql.push_back(n);
    @(posedge clk); #1;
    last_stop = st;
  endtask

  logic [25:0] pe[$];
  bit          pm[$];
  string       pn[$];

  task automatic step(input logic [25:0] e, input bit mr, input string n);
    pe.push_back(e | RUN); pm.push_back(mr); pn.push_back(n);
  endtask

  task automatic enter();
    while (last_stop) cyc(1'b0, 1'b0, rb(), rnd_stop(), '0, '0, "paused");
  endtask

  task automatic run_instr(input logic [4:0] op, input int w1, input int w6,
                           input int abort_at, input bit stop_end, input int hold);
    int c;
    logic [25:0] first_a;
    enter();
    ir = {op, 27'($urandom)};
    c  = cls_of(op);
    pe.delete(); pm.delete(); pn.delete();
    step(T0V, rb(), "T0");
    for (int k = 0; k < w1; k++) step(T1V, 1'b0, "T1wait");
    step(T1V, 1'b1, "T1");
    step(T2V, rb(), "T2");
    case (c)
      K_ALU3, K_IMM: begin
        step(GRB | ROUT | RYIN, rb(), "T3");
        step((c == K_ALU3) ? (GRC | ROUT | RZINLO) : (COUT | RZINLO), rb(), "T4");
        step(RZOUTLO | GRA | RIN, rb(), "T5");
      end
      K_MUL, K_DIV: begin
        step(GRA | ROUT | RYIN, rb(), "T3");
        step(GRB | ROUT | RZINLO | RZINHI, rb(), "T4");
        step(RZOUTLO | LOIN, rb(), "T5");
        step(RZOUTHI | HIIN, rb(), "T6");
      end
      K_LD, K_ST: begin
        step(GRB | BAOUT | RYIN, rb(), "T3");
        step(COUT | RZINLO, rb(), "T4");
        step(RZOUTLO | MARIN, rb(), "T5");
        if (c == K_LD) begin
          for (int k = 0; k < w6; k++) step(READ | MDRREAD | MDRIN, 1'b0, "T6wait");
          step(READ | MDRREAD | MDRIN, 1'b1, "T6");
          step(MDROUT | GRA | RIN, rb(), "T7");
        end else begin
          step(GRA | ROUT | MDRIN, rb(), "T6");
          for (int k = 0; k < w6; k++) step(WRITE, 1'b0, "T7wait");
          step(WRITE, 1'b1, "T7");
        end
      end
      K_UNDEF: step(ILL, rb(), "T3ill");
      default: step('0, rb(), "T3");
    endcase
    for (int i = 0; i < pe.size(); i++) begin
      if (i == abort_at) begin
        cyc(1'b1, 1'b1, pm[i], rnd_stop(), pe[i], pe[i], "abort");
        cyc(1'b0, 1'b0, rb(), rnd_stop(), '0, '0, "reset");
        return;
      end
      cyc(1'b0, 1'b0, pm[i], (i == pe.size() - 1) ? stop_end : rnd_stop(), pe[i], pe[i], pn[i]);
    end
    if (c == K_HALT) begin
      for (int k = 0; k < hold; k++) cyc(1'b0, 1'b0, rb(), rb(), '0, '0, "halted");
      cyc(1'b1, 1'b1, rb(), rb(), '0, '0, "halted_clear");
      cyc(1'b0, 1'b0, rb(), rnd_stop(), '0, '0, "reset");
    end else if (c == K_UNDEF) begin
      // The NOP-unit carries on (held in reset meanwhile); the HALT-unit sits halted.
      first_a = last_stop ? 26'h0 : T0V;
      cyc(1'b1, 1'b0, rb(), rb(), first_a, '0, "undef_after");
      for (int k = 1; k < hold; k++) cyc(1'b1, 1'b0, rb(), rb(), '0, '0, "undef_halted");
      cyc(1'b1, 1'b1, rb(), rb(), '0, '0, "undef_clear");
      cyc(1'b0, 1'b0, rb(), rnd_stop(), '0, '0, "reset");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    int ab;
    clear_a = 1'b1; clear_b = 1'b1; mem_ready = 1'b0; stop = 1'b0; last_stop = 1'b0;
    ir = '0;
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, "reset");
    run_instr(5'b00000, 0, 0, -1, 1'b0, 1);
    run_instr(5'b10010, 0, 3, -1, 1'b0, 1);
    run_instr(5'b10000, 1, 0, -1, 1'b0, 1);
    run_instr(5'b11111, 0, 0, -1, 1'b0, 20);
    run_instr(5'b11011, 2, 0, -1, 1'b0, 20);
    run_instr(5'b10011, 0, 2, -1, 1'b1, 1);
    run_instr(5'b10001, 0, 0, 4, 1'b0, 1);
    run_instr(5'b01110, 0, 0, -1, 1'b0, 1);
    run_instr(5'b11010, 0, 0, -1, 1'b0, 1);
    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ab, rnd_stop(),
                int'($urandom_range(1, 4)));
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", qa.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
